branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-side producer of branch guesses; the EX-stage comparator's br_en result is its consumer-side training input.
- Purpose: close the loop on br_en by predicting it in IF, then training on the resolved outcome in EX.
- Contents: 2-bit saturating-counter direction table plus a direct-mapped BTB.
- IF lookup is combinational from registered state. EX update and mispredict detection happen in one cycle. Resolution performance counters are included.

Parameters:
- IDX_W, 5, log2 of BHT/BTB entries (32 entries).
- TAG_W, 8, BTB tag bits taken from pc above the index.
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  32  fetch PC
- if_valid  in  1  lookup request this cycle
- if_pred_taken  out  1  predicted taken (BTB hit AND counter MSB=1)
- if_pred_target  out  32  BTB target; if_pc+4 when not predicted taken
- if_pred_idx  out  IDX_W  index used; carried down the pipe
- ex_valid  in  1  conditional branch resolving in EX this cycle
- ex_pc  in  32  PC of resolving branch
- ex_idx  in  IDX_W  if_pred_idx carried from IF
- ex_pred_taken  in  1  carried prediction
- ex_pred_target  in  32  carried predicted target
- ex_br_en  in  1  comparator outcome
- ex_target  in  32  computed taken target
- ex_mispredict  out  1  redirect request (combinational)
- ex_redirect_pc  out  32  ex_target if ex_br_en, else ex_pc+4
- branch_count  out  CNT_W  resolved-branch count
- mispredict_count  out  CNT_W  mispredict count

Behaviour:
- Reset (async, rst_n=0):
  - all BHT counters = WNT (2'b01); all BTB valid bits = 0.
  - branch_count = mispredict_count = 0; GHR = 0.
  - Combinational outputs follow from that state: if_pred_taken=0, if_pred_target=if_pc+4, ex_mispredict=0 when ex_valid=0.
- Index:
  - Default: pc[IDX_W+1:2].
  - Tag: pc[IDX_W+TAG_W+1:IDX_W+2].
  - ex_idx is used for the update, never recomputed from ex_pc. ex_pc supplies only the tag and ex_pc+4.
- Lookup (zero latency):
  - hit = valid[idx] & tag match.
  - if_pred_taken = if_valid & hit & ctr[idx][1].
  - if_valid=0 forces if_pred_taken=0.
- Mispredict (combinational, gated by ex_valid):
  - ex_mispredict = (ex_pred_taken != ex_br_en) | (ex_br_en & ex_pred_taken & ex_pred_target != ex_target).
- Update (rising clk, ex_valid=1):
  - ctr[ex_idx] increments if ex_br_en, else decrements; saturates at 2'b11 and 2'b00.
  - If ex_br_en=1: BTB[ex_idx] <= {valid=1, tag(ex_pc), ex_target}.
  - Not-taken outcomes never invalidate the BTB.
- Counters:
  - branch_count += 1 per ex_valid cycle; mispredict_count += 1 when ex_mispredict.
  - Both saturate at all-ones; neither wraps.
- Simultaneous lookup and update to the same idx: the lookup sees the pre-update value; no bypass.
- ex_valid=0: no state change; ex_mispredict=0.
- Reset mid-operation: all state returns immediately to reset values; any in-flight EX update in that cycle is dropped.

Optional Feature:
- Macro: BP_GSHARE_EN.
- Defined:
  - IDX_W-bit global history register GHR.
  - Lookup index = pc[IDX_W+1:2] XOR GHR.
  - GHR <= {GHR[IDX_W-2:0], ex_br_en} on each ex_valid. It is non-speculative, updated at resolution only.
  - GHR resets to 0.
  - BTB remains indexed by pc bits only. if_pred_idx carries the BHT index; the BTB index is recomputed from pc.
- Undefined: pure bimodal; no GHR flops exist.

Decomposition:
- Shared package, alongside rv32i_types:
  - bp_ctr_t enum: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - bp_btb_entry_t struct: valid, tag, target.
  - Default IDX_W/TAG_W constants.
- One sub-module: bp_btb (tag/target/valid array, async-reset valids, comb read, sync write). Counters and the FSM-free BHT stay in the top level.

Test Plan:
- Reset release, lookup if_pc=0x60 -> if_pred_taken=0, if_pred_target=0x64, both counters 0.
- Update idx of 0x60, br_en=1, target=0x100, pred_taken=0 -> ex_mispredict=1, redirect 0x100; next lookup of 0x60 -> taken, target 0x100 (ctr WT).
- Four consecutive taken updates on one entry then one not-taken -> counter ST then WT; prediction still taken.
- Aliasing pc 0x60 vs 0x60+(1<<(IDX_W+2)) (0xE0 at defaults) -> tag mismatch, if_pred_taken=0 despite ctr MSB=1.
- Same-cycle lookup and update on an entry at WNT with br_en=1 -> lookup returns not-taken; following cycle returns taken.
- Preload mispredict_count near all-ones (CNT_W reduced to 4 in bench), force 20 mispredicts -> holds at 4'hF. With BP_GSHARE_EN, alternating T/NT pattern -> mispredicts stop after warm-up.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types and defaults for the fetch-side branch predictor.
// Holds the counter encoding, BTB entry layout and default sizes.
package branch_predictor_pkg;

    localparam int BP_IDX_W = 5;
    localparam int BP_TAG_W = 8;
    localparam int BP_CNT_W = 32;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_t;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [31:0]         target;
    } bp_btb_entry_t;

    // Saturating step of a 2-bit direction counter
    function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t c,
                                            input logic    taken);
        bp_ctr_t n;
        n = c;
        if (taken) begin
            if (c != ST) n = bp_ctr_t'(c + 2'd1);
        end else begin
            if (c != SNT) n = bp_ctr_t'(c - 2'd1);
        end
        return n;
    endfunction

endpackage

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer: async-reset valids,
// combinational read port, synchronous write port.
import branch_predictor_pkg::*;

module bp_btb #(
    parameter int IDX_W = BP_IDX_W,
    parameter int TAG_W = BP_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_hit,
    output logic [31:0]      rd_target,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_target
);

    localparam int NENT = 1 << IDX_W;

    logic [NENT-1:0]  valid_q;
    logic [NENT-1:0]  valid_d;
    logic [TAG_W-1:0] tag_q    [NENT];
    logic [31:0]      target_q [NENT];

    // Read port: hit needs a valid entry with a matching tag
    always_comb begin
        rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        rd_target = target_q[rd_idx];
    end

    // Valid bits only ever get set; not-taken never clears them
    always_comb begin
        valid_d = valid_q;
        if (wr_en) valid_d[wr_idx] = 1'b1;
    end

    // Valid array clears on reset so stale tags are never used
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_q <= '0;
        else        valid_q <= valid_d;
    end

    // Tag/target payload needs no reset; guarded by valid
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal 2-bit BHT + BTB predictor with EX-stage training.
// Define BP_GSHARE_EN to XOR a global history into the BHT index.
import branch_predictor_pkg::*;

module branch_predictor #(
    parameter int IDX_W = BP_IDX_W,
    parameter int TAG_W = BP_TAG_W,
    parameter int CNT_W = BP_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      if_pc,
    input  logic             if_valid,
    output logic             if_pred_taken,
    output logic [31:0]      if_pred_target,
    output logic [IDX_W-1:0] if_pred_idx,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic [IDX_W-1:0] ex_idx,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    input  logic             ex_br_en,
    input  logic [31:0]      ex_target,
    output logic             ex_mispredict,
    output logic [31:0]      ex_redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int NENT = 1 << IDX_W;
    localparam int TLO  = IDX_W + 2;
    localparam int THI  = IDX_W + TAG_W + 1;

    bp_ctr_t          ctr_q [NENT];
    bp_ctr_t          ctr_d [NENT];
    logic [CNT_W-1:0] branch_count_q;
    logic [CNT_W-1:0] branch_count_d;
    logic [CNT_W-1:0] mispredict_count_q;
    logic [CNT_W-1:0] mispredict_count_d;

    logic [IDX_W-1:0] if_pc_idx;
    logic [IDX_W-1:0] if_bht_idx;
    logic [TAG_W-1:0] if_tag;
    logic             btb_hit;
    logic [31:0]      btb_target;
    logic [IDX_W-1:0] ex_btb_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             btb_wr;
    logic [31:0]      if_pc_inc;
    logic [31:0]      ex_pc_inc;

    assign if_pc_idx = if_pc[IDX_W+1:2];
    assign if_tag    = if_pc[THI:TLO];
    assign ex_tag    = ex_pc[THI:TLO];
    assign if_pc_inc = if_pc + 32'd4;
    assign ex_pc_inc = ex_pc + 32'd4;
    assign btb_wr    = ex_valid && ex_br_en;

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr_q;
    logic [IDX_W-1:0] ghr_d;

    // BHT index hashes PC with resolved history; BTB stays PC-indexed
    assign if_bht_idx = if_pc_idx ^ ghr_q;
    assign ex_btb_idx = ex_pc[IDX_W+1:2];

    // History shifts in each resolved outcome, never speculatively
    always_comb begin
        ghr_d = ghr_q;
        if (ex_valid) ghr_d = {ghr_q[IDX_W-2:0], ex_br_en};
    end

    // History register, cleared on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ghr_q <= '0;
        else        ghr_q <= ghr_d;
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], if_pc[31:THI+1],
                              ex_pc[1:0], ex_pc[31:THI+1]};
`else
    // Pure bimodal: one PC-derived index for both tables
    assign if_bht_idx = if_pc_idx;
    assign ex_btb_idx = ex_idx;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], if_pc[31:THI+1],
                              ex_pc[1:0], ex_pc[TLO-1:2],
                              ex_pc[31:THI+1]};
`endif

    bp_btb #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_btb (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (if_pc_idx),
        .rd_tag    (if_tag),
        .rd_hit    (btb_hit),
        .rd_target (btb_target),
        .wr_en     (btb_wr),
        .wr_idx    (ex_btb_idx),
        .wr_tag    (ex_tag),
        .wr_target (ex_target)
    );

    // IF lookup: taken only on a BTB hit with a taken-leaning counter
    always_comb begin
        if_pred_idx    = if_bht_idx;
        if_pred_taken  = if_valid && btb_hit && ctr_q[if_bht_idx][1];
        if_pred_target = if_pred_taken ? btb_target : if_pc_inc;
    end

    // EX check: wrong direction, or taken to the wrong target
    always_comb begin
        ex_mispredict = 1'b0;
        if (ex_valid) begin
            ex_mispredict = (ex_pred_taken != ex_br_en) ||
                            (ex_br_en && ex_pred_taken &&
                             (ex_pred_target != ex_target));
        end
        ex_redirect_pc = ex_br_en ? ex_target : ex_pc_inc;
    end

    // BHT training on the carried index
    always_comb begin
        for (int i = 0; i < NENT; i++) ctr_d[i] = ctr_q[i];
        if (ex_valid) ctr_d[ex_idx] = bp_ctr_next(ctr_q[ex_idx], ex_br_en);
    end

    // Saturating resolution counters
    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (ex_valid && (branch_count_q != '1))
            branch_count_d = branch_count_q + 1'b1;
        if (ex_mispredict && (mispredict_count_q != '1))
            mispredict_count_d = mispredict_count_q + 1'b1;
    end

    // BHT and counter state; reset drops any in-flight update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NENT; i++) ctr_q[i] <= WNT;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            for (int i = 0; i < NENT; i++) ctr_q[i] <= ctr_d[i];
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (bimodal build, CNT_W=4).
// Optional gshare warm-up section runs when BP_GSHARE_EN is defined.
module tb_branch_predictor;

    localparam int IDX_W = 5;
    localparam int TAG_W = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [31:0]      if_pc;
    logic             if_valid;
    logic             if_pred_taken;
    logic [31:0]      if_pred_target;
    logic [IDX_W-1:0] if_pred_idx;
    logic             ex_valid;
    logic [31:0]      ex_pc;
    logic [IDX_W-1:0] ex_idx;
    logic             ex_pred_taken;
    logic [31:0]      ex_pred_target;
    logic             ex_br_en;
    logic [31:0]      ex_target;
    logic             ex_mispredict;
    logic [31:0]      ex_redirect_pc;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    int n_cmp;
    int n_bad;

    branch_predictor #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc            (if_pc),
        .if_valid         (if_valid),
        .if_pred_taken    (if_pred_taken),
        .if_pred_target   (if_pred_target),
        .if_pred_idx      (if_pred_idx),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_idx           (ex_idx),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .ex_br_en         (ex_br_en),
        .ex_target        (ex_target),
        .ex_mispredict    (ex_mispredict),
        .ex_redirect_pc   (ex_redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Combinational lookup, sampled 1 time unit after driving
    task automatic look(input string tag, input logic [31:0] pc,
                        input logic exp_tk, input logic [31:0] exp_tg);
        if_pc    = pc;
        if_valid = 1'b1;
        #1;
        chk({tag, "_tk"}, 32'(if_pred_taken), 32'(exp_tk));
        chk({tag, "_tg"}, if_pred_target, exp_tg);
    endtask

    // One EX resolution: checks comb outputs, then clocks it in
    task automatic ex_go(input string tag, input logic [31:0] pc,
                         input logic [4:0] idx, input logic pt,
                         input logic [31:0] ptg, input logic br,
                         input logic [31:0] tg, input logic exp_mp,
                         input logic [31:0] exp_rd);
        ex_valid       = 1'b1;
        ex_pc          = pc;
        ex_idx         = idx;
        ex_pred_taken  = pt;
        ex_pred_target = ptg;
        ex_br_en       = br;
        ex_target      = tg;
        #1;
        chk({tag, "_mp"}, 32'(ex_mispredict), 32'(exp_mp));
        chk({tag, "_rd"}, ex_redirect_pc, exp_rd);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic cnts(input string tag, input int b, input int m);
        chk({tag, "_bc"}, 32'(branch_count), 32'(b));
        chk({tag, "_mc"}, 32'(mispredict_count), 32'(m));
    endtask

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        rst_n          = 1'b0;
        if_pc          = 32'h60;
        if_valid       = 1'b1;
        ex_valid       = 1'b0;
        ex_pc          = '0;
        ex_idx         = '0;
        ex_pred_taken  = 1'b0;
        ex_pred_target = '0;
        ex_br_en       = 1'b0;
        ex_target      = '0;

        // Reset state
        #2;
        look("rst", 32'h60, 1'b0, 32'h64);
        chk("rst_mp", 32'(ex_mispredict), 32'd0);
        cnts("rst", 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Lookup after reset; index of 0x60 is 24
        look("l0", 32'h60, 1'b0, 32'h64);
        chk("l0_idx", 32'(if_pred_idx), 32'd24);

        // First taken resolution: mispredict, redirect, WNT->WT
        ex_go("u1", 32'h60, 5'd24, 1'b0, 32'h64, 1'b1, 32'h100,
              1'b1, 32'h100);
        look("l1", 32'h60, 1'b1, 32'h100);
        cnts("u1", 1, 1);

        // Alias: same index, different tag
        look("alias", 32'hE0, 1'b0, 32'hE4);

        // if_valid low suppresses prediction
        if_valid = 1'b0;
        #1;
        chk("ifv0", 32'(if_pred_taken), 32'd0);
        if_valid = 1'b1;

        // Four correct taken: WT->ST, then NT: ST->WT
        for (int i = 0; i < 4; i++)
            ex_go("tk", 32'h60, 5'd24, 1'b1, 32'h100, 1'b1, 32'h100,
                  1'b0, 32'h100);
        cnts("tk4", 5, 1);
        ex_go("nt", 32'h60, 5'd24, 1'b1, 32'h100, 1'b0, 32'h100,
              1'b1, 32'h64);
        look("l_wt", 32'h60, 1'b1, 32'h100);
        cnts("nt", 6, 2);

        // Taken with wrong predicted target
        ex_go("wtg", 32'h60, 5'd24, 1'b1, 32'h200, 1'b1, 32'h100,
              1'b1, 32'h100);
        cnts("wtg", 7, 3);

        // Entry 0x40 (idx 16): valid BTB, counter back to WNT
        ex_go("s1", 32'h40, 5'd16, 1'b0, 32'h44, 1'b1, 32'h140,
              1'b1, 32'h140);
        ex_go("s2", 32'h40, 5'd16, 1'b1, 32'h140, 1'b0, 32'h140,
              1'b1, 32'h44);
        look("s_pre", 32'h40, 1'b0, 32'h44);

        // Same-cycle lookup and update: pre-update value seen
        if_pc          = 32'h40;
        ex_valid       = 1'b1;
        ex_pc          = 32'h40;
        ex_idx         = 5'd16;
        ex_pred_taken  = 1'b0;
        ex_pred_target = 32'h44;
        ex_br_en       = 1'b1;
        ex_target      = 32'h140;
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        @(negedge clk);
        look("s_post", 32'h40, 1'b1, 32'h140);
        cnts("s", 10, 6);

        // Idle EX with stray inputs: no mispredict, no state change
        ex_valid      = 1'b0;
        ex_br_en      = 1'b1;
        ex_pred_taken = 1'b0;
        #1;
        chk("idle_mp", 32'(ex_mispredict), 32'd0);
        @(negedge clk);
        cnts("idle", 10, 6);

        // 20 mispredicts: both counters saturate at 4'hF
        for (int i = 0; i < 20; i++)
            ex_go("sat", 32'h80, 5'd0, 1'b0, 32'h84, 1'b1, 32'h300,
                  1'b1, 32'h300);
        cnts("sat", 15, 15);

        // Mid-operation reset drops the in-flight update
        ex_valid      = 1'b1;
        ex_pc         = 32'h60;
        ex_idx        = 5'd24;
        ex_pred_taken = 1'b1;
        ex_br_en      = 1'b0;
        rst_n         = 1'b0;
        #1;
        cnts("mrst", 0, 0);
        look("mrst", 32'h60, 1'b0, 32'h64);
        @(posedge clk);
        @(negedge clk);
        ex_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        cnts("mrst2", 0, 0);
        look("mrst2", 32'h60, 1'b0, 32'h64);

`ifdef BP_GSHARE_EN
        // Alternating T/NT on one branch: history separates the
        // two phases, so mispredicts stop after warm-up
        begin
            logic [CNT_W-1:0] mc0;
            mc0 = '0;
            for (int i = 0; i < 16; i++) begin
                logic             pt;
                logic [31:0]      ptg;
                logic [IDX_W-1:0] pidx;
                if_pc = 32'h60;
                #1;
                pt   = if_pred_taken;
                ptg  = if_pred_target;
                pidx = if_pred_idx;
                if (i == 8) mc0 = mispredict_count;
                ex_valid       = 1'b1;
                ex_pc          = 32'h60;
                ex_idx         = pidx;
                ex_pred_taken  = pt;
                ex_pred_target = ptg;
                ex_br_en       = (i % 2 == 0);
                ex_target      = 32'h100;
                @(posedge clk);
                #1;
                ex_valid = 1'b0;
                @(negedge clk);
            end
            chk("gs_warm", 32'(mispredict_count), 32'(mc0));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    // Backstop so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", 1, 0);
        $fatal(1);
    end

endmodule
